// File: rtl/ibex_data_mem_resp.sv
// Memory-side responder for the Ibex LSU data port: grants under an outstanding limit,
// services word reads / byte-enabled writes, and returns in-order responses after a fixed latency.
// Optional grant-stall injection is enabled by defining IBEX_DATA_MEM_STALL_INJECT_EN.
module ibex_data_mem_resp #(
  parameter int unsigned DEPTH           = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
  localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [31:0] r_mem [DEPTH];

  logic [RESP_LATENCY-1:0]       r_vld;
  logic [RESP_LATENCY-1:0]       r_err;
  logic [RESP_LATENCY-1:0][31:0] r_dat;
  logic [3:0]                    r_outstanding;

  logic [32:0]      w_diff;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_has_slot;
  logic             w_stall_ok;
  logic             w_gnt;
  logic             w_wr_hit;
  logic             w_rd_hit;
  logic             w_unused_ok;

  // 33-bit difference: an address below BASE_ADDR borrows into bit 32 and fails the span test.
  assign w_diff      = {1'b0, data_addr_i} - {1'b0, BASE_ADDR};
  assign w_in_range  = (w_diff < SPAN);
  assign w_idx       = w_diff[IDX_W+1:2];
  assign w_unused_ok = ^{w_diff[32:IDX_W+2], w_diff[1:0]};

`ifdef IBEX_DATA_MEM_STALL_INJECT_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form).
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  assign w_stall_ok = (r_lfsr[1:0] != 2'b00);
`else
  assign w_stall_ok = 1'b1;
`endif

  assign w_has_slot = (r_outstanding < MAX_OUT);
  assign w_gnt      = data_req_i & w_has_slot & w_stall_ok & ~rst;
  assign w_wr_hit   = w_gnt &  data_we_i & w_in_range;
  assign w_rd_hit   = w_gnt & ~data_we_i & w_in_range;

  // Array is deliberately not reset; writes commit at the grant edge.
  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response shift register; empty stages carry zeros so outputs idle at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_err <= '0;
      r_dat <= '0;
    end else begin
      r_vld[0] <= w_gnt;
      r_err[0] <= w_gnt & ~w_in_range;
      r_dat[0] <= w_rd_hit ? r_mem[w_idx] : 32'h0;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= 4'd0;
    end else begin
      case ({w_gnt, data_rvalid_o})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = r_vld[RESP_LATENCY-1];
  assign data_err_o    = r_err[RESP_LATENCY-1];
  assign data_rdata_o  = r_dat[RESP_LATENCY-1];

endmodule

// File: tb/tb_ibex_data_mem_resp.sv
// Self-checking bench for ibex_data_mem_resp: two instances (latency 1 and 3) against a
// transaction-level model (response queue with due cycles, associative memory).
`timescale 1ns/1ps
module tb_ibex_data_mem_resp;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        req_s   [2];
  logic        we_s    [2];
  logic [3:0]  be_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        gnt_s   [2];
  logic        rvalid_s[2];
  logic [31:0] rdata_s [2];
  logic        err_s   [2];

  ibex_data_mem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .data_req_i(req_s[0]), .data_gnt_o(gnt_s[0]),
    .data_rvalid_o(rvalid_s[0]), .data_we_i(we_s[0]), .data_be_i(be_s[0]),
    .data_addr_i(addr_s[0]), .data_wdata_i(wdata_s[0]), .data_rdata_o(rdata_s[0]),
    .data_err_o(err_s[0]));

  ibex_data_mem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .data_req_i(req_s[1]), .data_gnt_o(gnt_s[1]),
    .data_rvalid_o(rvalid_s[1]), .data_we_i(we_s[1]), .data_be_i(be_s[1]),
    .data_addr_i(addr_s[1]), .data_wdata_i(wdata_s[1]), .data_rdata_o(rdata_s[1]),
    .data_err_o(err_s[1]));

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
    bit          known;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mem_m [int];
  logic [15:0] lfsr_m [2];
  int          cyc;
  int          sel;
  int          n_tests;
  int          n_fail;
  bit          last_eg;
  bit          gnt_log[$];
  bit          rv_log[$];

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  function automatic int max_of(input int s);
    return (s == 0) ? 2 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (dut%0d cyc %0d): observed %h expected %h", tag, sel, cyc, obs, exp);
    end
  endtask

  // One clock of the active instance: sample at negedge+1, compare with the model, then advance.
  task automatic step(input bit r);
    bit          eg;
    bit          erv;
    bit          inr;
    longint      a;
    int          key;
    logic [31:0] nv;
    resp_t       e;
    rst_s[sel] = r;
    #1;
    eg = req_s[sel] && !r && (q.size() < max_of(sel));
`ifdef IBEX_DATA_MEM_STALL_INJECT_EN
    eg = eg && (lfsr_m[sel][1:0] != 2'b00);
`endif
    erv = (q.size() > 0) && (q[0].due == cyc);
    gnt_log.push_back(gnt_s[sel]);
    rv_log.push_back(rvalid_s[sel]);
    check("gnt", 32'(gnt_s[sel]), 32'(eg));
    check("rvalid", 32'(rvalid_s[sel]), 32'(erv));
    if (erv) begin
      check("err", 32'(err_s[sel]), 32'(q[0].err));
      if (q[0].known) check("rdata", rdata_s[sel], q[0].data);
    end else begin
      check("idle_rdata", rdata_s[sel], 32'h0);
      check("idle_err", 32'(err_s[sel]), 32'h0);
    end
    last_eg = eg;
    if (r) begin
      q.delete();
    end else begin
      if (erv) void'(q.pop_front());
      if (eg) begin
        a   = longint'(addr_s[sel]);
        inr = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
        key = sel * 4096 + int'((a - longint'(BASE)) / 4);
        e.due = cyc + lat_of(sel);
        e.data = 32'h0;
        e.err = !inr;
        e.known = 1'b1;
        if (inr && we_s[sel]) begin
          nv = mem_m.exists(key) ? mem_m[key] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (be_s[sel][b]) nv[8*b +: 8] = wdata_s[sel][8*b +: 8];
          mem_m[key] = nv;
        end else if (inr) begin
          e.known = mem_m.exists(key);
          e.data  = e.known ? mem_m[key] : 32'h0;
        end
        q.push_back(e);
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (rst_s[s]) lfsr_m[s] = 16'hACE1;
      else          lfsr_m[s] = {^(lfsr_m[s] & 16'h002D), lfsr_m[s][15:1]};
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
    rst_s[sel] = 1'b0;
  endtask

  task automatic issue(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bit done;
    done = 1'b0;
    req_s[sel] = 1'b1; we_s[sel] = we; addr_s[sel] = a; be_s[sel] = be; wdata_s[sel] = wd;
    for (int k = 0; k < 64 && !done; k++) begin
      step(1'b0);
      done = last_eg;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $error("FAIL grant_timeout: observed no grant expected grant within 64 cycles");
    end
    req_s[sel] = 1'b0;
  endtask

  task automatic idle(input int n);
    req_s[sel] = 1'b0;
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  task automatic drain();
    req_s[sel] = 1'b0;
    for (int k = 0; k < 32 && q.size() > 0; k++) step(1'b0);
    if (q.size() > 0) begin
      n_tests++; n_fail++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          pending;
    bit          pat_g[8];
    bit          pat_r[8];
    logic [31:0] ra;
    n_tests = 0; n_fail = 0; cyc = 0; sel = 0;
    for (int s = 0; s < 2; s++) begin
      rst_s[s] = 1'b1; req_s[s] = 1'b0; we_s[s] = 1'b0; be_s[s] = 4'h0;
      addr_s[s] = 32'h0; wdata_s[s] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    lfsr_m[0] = 16'hACE1; lfsr_m[1] = 16'hACE1;

    // Reset state, and gnt held low while rst is high even with req asserted.
    idle(1);
    req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h0; be_s[0] = 4'hF;
    step(1'b1);
    idle(1);

    // Preload the working set of both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 4'hF, $urandom);
      drain();
    end

    // Latency-1 instance: write/read-after-write, byte enables, out-of-range.
    sel = 0;
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    issue(1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    issue(1'b0, 32'h23, 4'h1, 32'h0);
    idle(1);
    check("be_merge_word", mem_m[8], 32'h11BB33DD);
    issue(1'b0, 32'h1000, 4'hF, 32'h0);
    issue(1'b1, 32'h1000, 4'hF, 32'h5555AAAA);
    issue(1'b0, 32'h0, 4'hF, 32'h0);
    issue(1'b1, 32'h14, 4'h0, 32'hFFFFFFFF);
    issue(1'b0, 32'h14, 4'hF, 32'h0);
    drain();

    // Latency-3 instance: outstanding limit with req held high.
    sel = 1;
    gnt_log.delete(); rv_log.delete();
    for (int i = 1; i <= 5; i++) issue(1'b0, 32'(i * 4), 4'hF, 32'h0);
    drain();
`ifndef IBEX_DATA_MEM_STALL_INJECT_EN
    pat_g = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    pat_r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("limit_gnt_c%0d", i), 32'(gnt_log[i]), 32'(pat_g[i]));
      check($sformatf("limit_rvalid_c%0d", i), 32'(rv_log[i]), 32'(pat_r[i]));
    end
`endif

    // Reset with a read in flight: no response may appear, then full capacity is available.
    issue(1'b0, 32'h8, 4'hF, 32'h0);
    step(1'b1);
    idle(5);
    issue(1'b0, 32'hC, 4'hF, 32'h0);
    issue(1'b0, 32'h10, 4'hF, 32'h0);
    drain();

    // Randomized traffic on each instance.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      pending = 1'b0;
      for (int t = 0; t < 200; t++) begin
        if (!pending && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 9))
            0:       ra = 32'h1000 + 32'($urandom_range(0, 7));
            1:       ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: ra = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
          endcase
          req_s[sel] = 1'b1; we_s[sel] = $urandom_range(0, 1) == 1;
          addr_s[sel] = ra; be_s[sel] = 4'($urandom_range(0, 15)); wdata_s[sel] = $urandom;
          pending = 1'b1;
        end
        step(1'b0);
        if (last_eg) begin
          pending = 1'b0;
          req_s[sel] = 1'b0;
        end
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_data_mem_resp.md
Name: ibex_data_mem_resp

Overview:
- Synthesizable data-memory responder for the Ibex LSU data port: the memory end of the data_req/gnt/rvalid protocol.
- Accepts LSU requests, grants them subject to an outstanding-request limit, and performs word reads and byte-enabled writes on an internal array.
- Returns in-order responses (rdata/err) a fixed number of cycles after grant.
- Used as the DUT-side memory in the LSU environment and as a reference responder for the driver.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned
- RESP_LATENCY, 1, cycles from grant to rvalid; legal range 1..8
- MAX_OUTSTANDING, 2, maximum granted requests without rvalid; legal range 1..RESP_LATENCY+1

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous active-high reset
- data_req_i  input  1  LSU request valid
- data_gnt_o  output  1  request accepted this cycle
- data_rvalid_o  output  1  response valid; single-cycle pulse per response
- data_we_i  input  1  1 = write, 0 = read
- data_be_i  input  4  byte enables; bit n selects bits 8n+7:8n
- data_addr_i  input  32  byte address
- data_wdata_i  input  32  write data
- data_rdata_o  output  32  read data, valid with rvalid
- data_err_o  output  1  error flag, valid with rvalid

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0. Outstanding count=0; response pipeline cleared. Array contents are not reset.
- Grant (combinational):
  - data_gnt_o = data_req_i & (outstanding < MAX_OUTSTANDING) & ~rst.
  - Handshake completes when req & gnt at posedge.
  - Request inputs are sampled only at that edge.
  - Request held without grant: no state change.
- Address decode:
  - idx = (data_addr_i - BASE_ADDR) >> 2; addr[1:0] ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH; otherwise error.
- Write (granted, in range): array[idx] byte n <= wdata byte n for each be[n]=1, committed at the grant edge. be=4'b0000 is a legal no-op write.
- Read (granted, in range): full 32-bit array[idx] captured at the grant edge; be does not mask read data.
- Read-after-write: a read granted the cycle after a write to the same word returns the new data.
- Error access: no array update; rdata=0, err=1.
- Response data for writes: rdata=0, err=0.
- Response pipeline:
  - Shift register of RESP_LATENCY stages, each holding {valid, rdata, err}.
  - Stage 0 loaded at grant; rvalid/rdata/err come from the last stage, registered.
  - rvalid rises exactly RESP_LATENCY cycles after the grant edge.
  - When rvalid=0, rdata=0 and err=0.
  - Responses are strictly in grant order. Back-to-back grants give back-to-back rvalids.
- Outstanding counter:
  - +1 on grant; -1 when rvalid is asserted; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING, never underflows.
  - At the limit, gnt=0 until an rvalid frees a slot. In the cycle rvalid is asserted the count is still at the limit, so gnt is 0; grant resumes the next cycle.
- Reset mid-operation: in-flight responses are discarded (no rvalid), and writes already granted stay committed.

Optional Feature:
- Macro: IBEX_DATA_MEM_STALL_INJECT_EN.
- When defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1, advancing every cycle out of reset.
  - data_gnt_o is additionally gated by (lfsr[1:0] != 2'b00), giving pseudo-random grant stalls to exercise LSU wait handling.
  - Response latency is unaffected.
- When undefined: no LFSR logic; grant depends only on req and capacity.

Test Plan:
- Write then read, RESP_LATENCY=1:
  - Write addr 32'h10, be 4'hF, wdata 32'hDEADBEEF; gnt in the same cycle; rvalid 1 cycle later with err=0, rdata=0.
  - Read addr 32'h10 returns 32'hDEADBEEF.
- Byte-enable write: preload 32'h11223344 at 32'h20; write be 4'b0101, wdata 32'hAABBCCDD; read returns 32'h11BB33DD.
- Out of range, DEPTH=1024: read addr 32'h1000 gives rvalid with err=1, rdata=0. Write to 32'h1000 followed by a read of word 0 shows word 0 unchanged.
- Outstanding limit, RESP_LATENCY=3, MAX_OUTSTANDING=2:
  - req held high for 8 cycles; gnt at cycles 0 and 1, 0 at cycles 2-3, 1 again at cycle 4.
  - rvalid at cycles 3, 4, 7; order preserved.
- Reset mid-flight: grant a read at cycle 0 with RESP_LATENCY=3; assert rst at cycle 1. No rvalid appears; outputs are 0 and count is 0 after reset.
- With IBEX_DATA_MEM_STALL_INJECT_EN, req held high: gnt is 0 exactly when lfsr[1:0]==00 (first cycles predicted from seed 16'hACE1). All responses still arrive RESP_LATENCY cycles after their grant.
